pipe_out_fifo: RTL and testbench
================================

PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter AF_MARGIN, default 1, giving the free-entry threshold for almost_full; it SHALL be between 1 and DEPTH-1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_data  input  WIDTH  result word from the upstream valid-only pipeline stage (its c output).
REQ-008 in_valid  input  1  in_data is valid this cycle; it has no backpressure and the block SHALL NOT stall it.
REQ-009 out_data  output  WIDTH  head-of-queue word.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  the downstream consumer accepts the word.
REQ-012 count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-013 almost_full  output  1  count >= DEPTH-AF_MARGIN; the upstream block uses it to gate its in_valid.
REQ-014 overflow  output  1  sticky flag: a word was dropped.

Function
REQ-015 The block SHALL be a first-word-fall-through circular buffer with registered read pointer, write pointer and occupancy count; all outputs SHALL derive from registers only, with no combinational path from in_valid or in_data to any output.
REQ-016 push = in_valid and (count < DEPTH, or pop in the same cycle).
REQ-017 pop = out_valid and out_ready.
REQ-018 A push SHALL write in_data at the write pointer; the write pointer SHALL advance by 1, modulo DEPTH.
REQ-019 A pop SHALL advance the read pointer by 1, modulo DEPTH.
REQ-020 count SHALL change per cycle as follows:
- +1 on push only
- -1 on pop only
- unchanged on both or neither.
REQ-021 Latency SHALL be exactly one cycle: a word pushed at edge N is visible on out_data with out_valid=1 after edge N, with no same-cycle bypass.
REQ-022 out_valid SHALL equal (count != 0); out_data SHALL equal the entry at the read pointer and is don't-care while out_valid=0.
REQ-023 Full with in_valid=1 and a pop in the same cycle: the block SHALL accept the word, and count SHALL stay at DEPTH.
REQ-024 Full with in_valid=1 and no pop: the block SHALL drop the word, leave the storage, pointers and count unchanged, and set overflow=1 from the next cycle.
REQ-025 overflow SHALL stay set until reset.
REQ-026 Empty with out_ready=1: no pop SHALL occur, and count SHALL NOT underflow.
REQ-027 The block SHALL preserve word order exactly, including across pointer wrap-around.
REQ-028 almost_full SHALL be computed from the registered count.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL set count, both pointers and overflow to 0; after that edge, out_valid=0, almost_full=0 and overflow=0.
REQ-030 Reset SHALL take priority over simultaneous push and pop; a word presented during reset SHALL be discarded and SHALL NOT set overflow.
REQ-031 Storage contents SHALL NOT be reset.

Verification
REQ-032 Single word: from reset, send in_data=0x00000005 with in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=0x5, count=1; raise out_ready for one cycle -> count=0, out_valid=0.
REQ-033 Fill: with out_ready=0, push 0x10, 0x11, 0x12, 0x13 on consecutive cycles -> almost_full=1 after the 3rd push, count=4 after the 4th; then drain with out_ready=1 -> out_data reads 0x10, 0x11, 0x12, 0x13 in order.
REQ-034 Overflow: with the block full and out_ready=0, push 0xDEAD -> count stays 4, overflow=1 and stays 1; the drain shows no 0xDEAD.
REQ-035 Full with simultaneous push and pop: full holding 0x10..0x13, in_valid=1 with in_data=0x20 and out_ready=1 -> 0x10 leaves, count=4, overflow=0; the drain yields 0x11, 0x12, 0x13, 0x20.
REQ-036 Wrap-around: stream 0x0..0x9 with in_valid=1 continuously and out_ready=1 continuously -> out_data yields 0x0..0x9 in order, each one cycle after its push; count never exceeds 1.
REQ-037 Reset mid-operation: with count=3 and overflow=1, assert rst for one cycle with in_valid=1 -> count=0, out_valid=0, overflow=0; the word presented during reset never appears on out_data.

Source files
------------

// File: rtl/pipe_out_fifo.sv
// First-word-fall-through output queue behind a valid-only pipeline stage.
// Words are never stalled upstream: a full queue without a pop drops the word and latches overflow.
module pipe_out_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             push;
    logic             pop;

    // Every output is a function of registered state only; in_valid/in_data reach
    // nothing visible until the next edge.
    assign full        = (count == FULL_CNT);
    assign out_valid   = (count != '0);
    assign out_data    = mem[rd_ptr];
    assign almost_full = (count >= AF_CNT);

    // A pop frees the head slot this cycle, so a full queue can still take a word.
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (in_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Bench for pipe_out_fifo: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the output FIFO.
module tb_pipe_out_fifo;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 1;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] mq[$];
    bit               m_ovf = 1'b0;
    bit               bad_seen = 1'b0;
    logic [WIDTH-1:0] poison = '0;
    bit               poison_live = 1'b0;

    always #5 clk = ~clk;

    pipe_out_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .almost_full(almost_full),
        .overflow(overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs, update the model, then
    // compare every output against it.
    task automatic cycle();
        bit do_pop;
        bit do_push;
        int sz;
        sz      = mq.size();
        do_pop  = (sz != 0) && out_ready;
        do_push = in_valid && ((sz < DEPTH) || do_pop);
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
            if (in_valid && !do_push) m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_val("count", 64'(count), 64'(mq.size()));
        check_val("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check_val("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - AF_MARGIN));
        check_val("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            check_val("out_data", 64'(out_data), 64'(mq[0]));
            if (poison_live && out_data == poison) bad_seen = 1'b1;
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit rdy);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        cycle();
    endtask

    task automatic fill_10_13();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, WIDTH'(32'h10 + i), 1'b0);
            if (i == 2) check_val("af_after_3rd", 64'(almost_full), 64'd1);
        end
        check_val("fill_count", 64'(count), 64'd4);
    endtask

    // Pop one word, checking it is the expected head before the edge.
    task automatic drain_expect(input logic [WIDTH-1:0] exp);
        check_val("drain_word", 64'(out_data), 64'(exp));
        drive(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cycle();
        cycle();
        check_val("reset_count", 64'(count), 64'd0);
        check_val("reset_valid", 64'(out_valid), 64'd0);

        // single word
        drive(1'b0, 1'b1, 32'h5, 1'b0);
        check_val("single_data", 64'(out_data), 64'h5);
        check_val("single_count", 64'(count), 64'd1);
        drive(1'b0, 1'b0, '0, 1'b1);
        check_val("single_empty", 64'(out_valid), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b1);
        check_val("no_underflow", 64'(count), 64'd0);

        // fill, overflow, drain
        fill_10_13();
        drive(1'b0, 1'b1, 32'hDEAD, 1'b0);
        check_val("ovf_count", 64'(count), 64'd4);
        check_val("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) drain_expect(WIDTH'(32'h10 + i));
        check_val("ovf_sticky", 64'(overflow), 64'd1);
        check_val("ovf_drained", 64'(out_valid), 64'd0);

        // full with simultaneous push and pop
        drive(1'b1, 1'b0, '0, 1'b0);
        fill_10_13();
        drive(1'b0, 1'b1, 32'h20, 1'b1);
        check_val("pp_count", 64'(count), 64'd4);
        check_val("pp_ovf", 64'(overflow), 64'd0);
        drain_expect(32'h11);
        drain_expect(32'h12);
        drain_expect(32'h13);
        drain_expect(32'h20);

        // streaming through the pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, WIDTH'(i), 1'b1);
            check_val("stream_word", 64'(out_data), 64'(i));
            check_val("stream_le1", 64'(count <= 1), 64'd1);
        end
        drive(1'b0, 1'b0, '0, 1'b1);

        // reset mid-operation with a word presented
        fill_10_13();
        drive(1'b0, 1'b1, 32'hDEAD, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1);
        check_val("pre_rst_count", 64'(count), 64'd3);
        poison = 32'hBAD0BAD0;
        poison_live = 1'b1;
        drive(1'b1, 1'b1, poison, 1'b0);
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_ovf", 64'(overflow), 64'd0);
        drive(1'b0, 1'b1, 32'h77, 1'b0);
        check_val("post_rst_word", 64'(out_data), 64'h77);

        // randomized traffic with varying bias and occasional reset
        for (int seg = 0; seg < 12; seg++) begin
            int pv = $urandom_range(1, 9);
            int pr = $urandom_range(1, 9);
            for (int i = 0; i < 200; i++) begin
                drive($urandom_range(0, 149) == 0,
                      $urandom_range(0, 9) < pv,
                      WIDTH'($urandom),
                      $urandom_range(0, 9) < pr);
            end
        end
        check_val("poison_never_out", 64'(bad_seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
